// File: rtl/interrupt_sequencer_if.sv
// Control bundle between the interrupt sequencer, the decoder and the dataflow block.
// The sequencer takes the master side; decoder/datapath see the slave side.
interface interrupt_sequencer_if;
    logic       instr_boundary;
    logic       brk_req;
    logic       irq;
    logic       nmi;
    logic       psr_i;
    logic       busy;
    logic [1:0] push_sel;
    logic       load_dor;
    logic       write_en;
    logic       stack_addr;
    logic       sp_dec;
    logic       vector_fetch;
    logic [7:0] vec_adl;
    logic       load_pcl;
    logic       load_pch;
    logic       set_i;
    logic       break_flag;
    logic [1:0] src;
    logic       done;

    modport master (
        input  instr_boundary, brk_req, irq, nmi, psr_i,
        output busy, push_sel, load_dor, write_en, stack_addr, sp_dec,
        output vector_fetch, vec_adl, load_pcl, load_pch, set_i,
        output break_flag, src, done
    );

    modport slave (
        output instr_boundary, brk_req, irq, nmi, psr_i,
        input  busy, push_sel, load_dor, write_en, stack_addr, sp_dec,
        input  vector_fetch, vec_adl, load_pcl, load_pch, set_i,
        input  break_flag, src, done
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt/reset entry sequencer: push PCH, PCL, PSR then fetch vector.
// Control strobes are registered and decoded from the upcoming state and source.
module interrupt_sequencer #(
    parameter logic [7:0] VEC_NMI    = 8'hFA,
    parameter logic [7:0] VEC_RESET  = 8'hFC,
    parameter logic [7:0] VEC_IRQ    = 8'hFE,
    parameter logic [7:0] VEC_PAGE   = 8'hFF,
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic                  clk,
    input  logic                  rst,
    interrupt_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        HOLD, IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI
    } state_e;

    typedef enum logic [1:0] {
        SRC_RESET = 2'b00,
        SRC_NMI   = 2'b01,
        SRC_IRQ   = 2'b10,
        SRC_BRK   = 2'b11
    } src_e;

    typedef struct packed {
        logic       busy;
        logic [1:0] push_sel;
        logic       load_dor;
        logic       write_en;
        logic       stack_addr;
        logic       sp_dec;
        logic       vector_fetch;
        logic [7:0] vec_adl;
        logic       load_pcl;
        logic       load_pch;
        logic       set_i;
        logic       break_flag;
        logic       done;
    } ctl_t;

    state_e state_q, state_d;
    src_e   src_q, src_d;
    logic   brk_q, brk_d;
    logic   pend_q, pend_d;
    logic   nmi_q;
    ctl_t   ctl_q;
    logic   nmi_rise;

    // Page constants are applied by the dataflow block from stack_addr/vector_fetch.
    logic unused_pages;
    assign unused_pages = ^{VEC_PAGE, STACK_PAGE};

    function automatic logic [7:0] vec_base(src_e s);
        logic [7:0] v;
        unique case (s)
            SRC_RESET: v = VEC_RESET;
            SRC_NMI:   v = VEC_NMI;
            default:   v = VEC_IRQ;
        endcase
        return v;
    endfunction

    function automatic ctl_t decode(state_e st, src_e s, logic brk);
        ctl_t c;
        logic wr;
        c      = '0;
        wr     = (s != SRC_RESET);
        c.busy = (st != IDLE);
        unique case (st)
            PUSH_PCH, PUSH_PCL, PUSH_PSR: begin
                c.stack_addr = 1'b1;
                c.sp_dec     = 1'b1;
                c.load_dor   = wr;
                c.write_en   = wr;
                unique case (st)
                    PUSH_PCH: c.push_sel = 2'b01;
                    PUSH_PCL: c.push_sel = 2'b10;
                    default: begin
                        c.push_sel   = 2'b11;
                        c.break_flag = brk;
                    end
                endcase
            end
            VEC_LO: begin
                c.vector_fetch = 1'b1;
                c.load_pcl     = 1'b1;
                c.set_i        = 1'b1;
                c.vec_adl      = vec_base(s);
            end
            VEC_HI: begin
                c.vector_fetch = 1'b1;
                c.load_pch     = 1'b1;
                c.done         = 1'b1;
                c.vec_adl      = vec_base(s) + 8'd1;
            end
            default: ;
        endcase
        return c;
    endfunction

    assign nmi_rise = bus.nmi & ~nmi_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        brk_d   = brk_q;
        pend_d  = pend_q | (nmi_rise & (state_q != HOLD));
        unique case (state_q)
            HOLD: begin
                state_d = PUSH_PCH;
                src_d   = SRC_RESET;
                brk_d   = 1'b0;
            end
            IDLE: begin
                if (bus.instr_boundary) begin
                    if (pend_q) begin
                        state_d = PUSH_PCH;
                        src_d   = SRC_NMI;
                        brk_d   = 1'b0;
                    end else if (bus.irq && !bus.psr_i) begin
                        state_d = PUSH_PCH;
                        src_d   = SRC_IRQ;
                        brk_d   = 1'b0;
                    end else if (bus.brk_req) begin
                        state_d = PUSH_PCH;
                        src_d   = SRC_BRK;
                        brk_d   = 1'b1;
                    end
                end
            end
            PUSH_PCH, PUSH_PCL, PUSH_PSR: begin
                unique case (state_q)
                    PUSH_PCH: state_d = PUSH_PCL;
                    PUSH_PCL: state_d = PUSH_PSR;
                    default:  state_d = VEC_LO;
                endcase
                // A pending NMI steals an IRQ/BRK entry; RESET is never stolen.
                if (pend_q && (src_q == SRC_IRQ || src_q == SRC_BRK))
                    src_d = SRC_NMI;
            end
            VEC_LO: begin
                state_d = VEC_HI;
                if (src_q == SRC_NMI)
                    pend_d = nmi_rise;
            end
            VEC_HI:  state_d = IDLE;
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD;
            src_q   <= SRC_RESET;
            brk_q   <= 1'b0;
            pend_q  <= 1'b0;
            nmi_q   <= 1'b0;
            ctl_q   <= decode(HOLD, SRC_RESET, 1'b0);
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            brk_q   <= brk_d;
            pend_q  <= pend_d;
            nmi_q   <= bus.nmi;
            ctl_q   <= decode(state_d, src_d, brk_d);
        end
    end

    assign bus.busy         = ctl_q.busy;
    assign bus.push_sel     = ctl_q.push_sel;
    assign bus.load_dor     = ctl_q.load_dor;
    assign bus.write_en     = ctl_q.write_en;
    assign bus.stack_addr   = ctl_q.stack_addr;
    assign bus.sp_dec       = ctl_q.sp_dec;
    assign bus.vector_fetch = ctl_q.vector_fetch;
    assign bus.vec_adl      = ctl_q.vec_adl;
    assign bus.load_pcl     = ctl_q.load_pcl;
    assign bus.load_pch     = ctl_q.load_pch;
    assign bus.set_i        = ctl_q.set_i;
    assign bus.break_flag   = ctl_q.break_flag;
    assign bus.src          = src_q;
    assign bus.done         = ctl_q.done;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: cycle model compared every negedge,
// plus directed scenarios with literal expectations.
module tb_interrupt_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;

    interrupt_sequencer_if sif();

    interrupt_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    // Model: hold flag, position in the 5-cycle entry (0 = idle), source.
    bit       m_hold;
    bit       m_pend;
    bit       m_nprev;
    int       m_pos;
    bit [1:0] m_src;
    bit       m_brk;

    task automatic model_step();
        bit rise;
        bit old_pend;
        bit was_hold;
        bit clr;
        if (rst) begin
            m_hold  = 1'b1;
            m_pend  = 1'b0;
            m_nprev = 1'b0;
            m_pos   = 0;
            m_src   = 2'd0;
            m_brk   = 1'b0;
        end else begin
            rise     = sif.nmi && !m_nprev;
            old_pend = m_pend;
            was_hold = m_hold;
            clr      = 1'b0;
            if (m_hold) begin
                m_hold = 1'b0;
                m_pos  = 1;
                m_src  = 2'd0;
                m_brk  = 1'b0;
            end else if (m_pos == 0) begin
                if (sif.instr_boundary) begin
                    if (old_pend) begin
                        m_pos = 1; m_src = 2'd1; m_brk = 1'b0;
                    end else if (sif.irq && !sif.psr_i) begin
                        m_pos = 1; m_src = 2'd2; m_brk = 1'b0;
                    end else if (sif.brk_req) begin
                        m_pos = 1; m_src = 2'd3; m_brk = 1'b1;
                    end
                end
            end else begin
                if (m_pos <= 3 && old_pend && m_src >= 2'd2)
                    m_src = 2'd1;
                if (m_pos == 4 && m_src == 2'd1)
                    clr = 1'b1;
                m_pos = (m_pos == 5) ? 0 : m_pos + 1;
            end
            if (!was_hold)
                m_pend = clr ? rise : (old_pend | rise);
            m_nprev = sif.nmi;
        end
    endtask

    function automatic logic [22:0] model_out();
        bit         push;
        logic [7:0] base;
        logic [7:0] v;
        push = (m_pos >= 1 && m_pos <= 3);
        base = (m_src == 2'd0) ? 8'hFC : (m_src == 2'd1) ? 8'hFA : 8'hFE;
        v    = (m_pos == 4) ? base : (m_pos == 5) ? base + 8'd1 : 8'h00;
        return {m_hold || m_pos != 0,
                push ? m_pos[1:0] : 2'b00,
                push && m_src != 2'd0,
                push && m_src != 2'd0,
                push, push,
                m_pos >= 4, v,
                m_pos == 4, m_pos == 5, m_pos == 4,
                m_pos == 3 && m_brk,
                m_src, m_pos == 5};
    endfunction

    function automatic logic [22:0] dut_out();
        return {sif.busy, sif.push_sel, sif.load_dor, sif.write_en,
                sif.stack_addr, sif.sp_dec, sif.vector_fetch, sif.vec_adl,
                sif.load_pcl, sif.load_pch, sif.set_i, sif.break_flag,
                sif.src, sif.done};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_total++;
            if (dut_out() === model_out())
                n_pass++;
            else
                $display("FAIL cycle t=%0t outputs got %h expected %h",
                         $time, dut_out(), model_out());
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int         n_we, n_sp, n_done, n_brk, n_seti, brk_sel;
    logic [1:0] last_src;
    logic [7:0] vq[$];
    logic [1:0] pq[$];

    task automatic obs_seq(input int nmi_at);
        n_we = 0; n_sp = 0; n_done = 0; n_brk = 0; n_seti = 0;
        brk_sel = 0;
        vq.delete();
        pq.delete();
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) begin
                sif.instr_boundary = 1'b0;
                sif.brk_req = 1'b0;
                sif.irq = 1'b0;
            end
            n_we   += int'(sif.write_en);
            n_sp   += int'(sif.sp_dec);
            n_done += int'(sif.done);
            n_seti += int'(sif.set_i);
            if (sif.load_dor) pq.push_back(sif.push_sel);
            if (sif.vector_fetch) vq.push_back(sif.vec_adl);
            if (sif.break_flag) begin
                n_brk++;
                brk_sel = int'(sif.push_sel);
            end
            last_src = sif.src;
            if (i == nmi_at) sif.nmi = 1'b1;
        end
    endtask

    task automatic chk_vec(input string name, input logic [7:0] lo);
        chk({name, " nvec"}, vq.size(), 2);
        chk({name, " vec_lo"}, vq.size() > 0 ? vq[0] : 8'hxx, lo);
        chk({name, " vec_hi"}, vq.size() > 1 ? vq[1] : 8'hxx, lo + 8'd1);
    endtask

    initial begin
        sif.instr_boundary = 1'b0;
        sif.brk_req = 1'b0;
        sif.irq = 1'b0;
        sif.nmi = 1'b0;
        sif.psr_i = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        chk("rst busy", sif.busy, 1);
        chk("rst write_en", sif.write_en, 0);
        chk("rst src", sif.src, 0);

        rst = 1'b0;
        obs_seq(0);
        chk_vec("reset", 8'hFC);
        chk("reset we", n_we, 0);
        chk("reset pushes", pq.size(), 0);
        chk("reset sp_dec", n_sp, 3);
        chk("reset done", n_done, 1);
        chk("reset set_i", n_seti, 1);
        chk("reset src", last_src, 0);
        step();
        chk("reset idle", sif.busy, 0);

        sif.irq = 1'b1; sif.psr_i = 1'b0; sif.instr_boundary = 1'b1;
        obs_seq(0);
        chk("irq npush", pq.size(), 3);
        chk("irq seq", {pq.size() > 2 ? pq[0] : 2'bxx,
                        pq.size() > 2 ? pq[1] : 2'bxx,
                        pq.size() > 2 ? pq[2] : 2'bxx}, 6'b01_10_11);
        chk_vec("irq", 8'hFE);
        chk("irq we", n_we, 3);
        chk("irq brk", n_brk, 0);
        chk("irq src", last_src, 2);
        step();
        chk("irq idle", sif.busy, 0);

        sif.psr_i = 1'b1; sif.irq = 1'b1; sif.brk_req = 1'b1;
        sif.instr_boundary = 1'b1;
        obs_seq(0);
        chk("brk src", last_src, 3);
        chk("brk flag n", n_brk, 1);
        chk("brk flag at psr", brk_sel, 3);
        chk_vec("brk", 8'hFE);
        sif.psr_i = 1'b0;
        step();

        sif.nmi = 1'b1;
        step();
        sif.nmi = 1'b0;
        step();
        step();
        chk("nmi wait idle", sif.busy, 0);
        sif.irq = 1'b1; sif.instr_boundary = 1'b1;
        obs_seq(4);
        chk("nmi src", last_src, 1);
        chk_vec("nmi", 8'hFA);
        chk("nmi we", n_we, 3);
        step();
        chk("nmi idle", sif.busy, 0);
        sif.instr_boundary = 1'b1;
        obs_seq(0);
        chk("nmi vec_lo edge src", last_src, 1);
        chk_vec("nmi2", 8'hFA);
        sif.instr_boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nmi held no retrigger", sif.busy, 0);
        end
        sif.instr_boundary = 1'b0;
        sif.nmi = 1'b0;
        step();

        sif.psr_i = 1'b1; sif.brk_req = 1'b1; sif.instr_boundary = 1'b1;
        obs_seq(2);
        chk("hijack brk n", n_brk, 1);
        chk("hijack brk at psr", brk_sel, 3);
        chk("hijack src", last_src, 1);
        chk("hijack we", n_we, 3);
        chk_vec("hijack", 8'hFA);
        sif.nmi = 1'b0; sif.psr_i = 1'b0; sif.instr_boundary = 1'b1;
        step();
        step();
        chk("hijack pend clear", sif.busy, 0);
        sif.instr_boundary = 1'b0;
        step();

        sif.irq = 1'b1; sif.instr_boundary = 1'b1;
        step();
        sif.irq = 1'b0; sif.instr_boundary = 1'b0;
        chk("abort pch", sif.push_sel, 1);
        step();
        chk("abort pcl we", sif.write_en, 1);
        rst = 1'b1;
        step();
        chk("abort we", sif.write_en, 0);
        chk("abort busy", sif.busy, 1);
        chk("abort push", sif.push_sel, 0);
        chk("abort src", sif.src, 0);
        step();
        rst = 1'b0;
        obs_seq(0);
        chk_vec("abort reset", 8'hFC);
        chk("abort reset we", n_we, 0);
        chk("abort reset sp", n_sp, 3);
        step();
        chk("abort idle", sif.busy, 0);

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
